// File: rtl/pool2d_stream_if.sv
// pool2d_stream_if: control, pixel-in and pooled-out signals of the pooling stage
interface pool2d_stream_if #(parameter int CH = 32, parameter int DW = 8);
  logic            start;
  logic [15:0]     col;
  logic [15:0]     row;
  logic            pool_en;
  logic            avg_mode;
  logic            valid_in;
  logic [CH*DW-1:0] data_in;
  logic            valid_out;
  logic [CH*DW-1:0] data_out;
  logic            pool_end;
  logic            busy;
  logic            cfg_err;
  modport master (
    output start, col, row, pool_en, avg_mode, valid_in, data_in,
    input  valid_out, data_out, pool_end, busy, cfg_err
  );
  modport slave (
    input  start, col, row, pool_en, avg_mode, valid_in, data_in,
    output valid_out, data_out, pool_end, busy, cfg_err
  );
endinterface

// File: rtl/pool2d_stream.sv
// pool2d_stream: 2x2/stride-2 max-pool (average pool when POOL_AVG_EN is defined) with registered bypass
module pool2d_stream #(
  parameter int CH      = 32,
  parameter int DW      = 8,
  parameter int MAX_COL = 256
) (
  input logic              clk,
  input logic              rst_n,
  pool2d_stream_if.slave   s
);
`ifdef POOL_AVG_EN
  localparam int HW = DW + 1;
`else
  localparam int HW = DW;
`endif
  localparam int AW = (MAX_COL > 2) ? $clog2(MAX_COL / 2) : 1;
  localparam logic [16:0] MAXC = 17'(MAX_COL);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [15:0] col_q, row_q, c_q, r_q;
  logic pool_q, cfg_err_q, valid_out_q, pool_end_q;
  logic [CH*DW-1:0] data_out_q, pooled;
  logic [CH-1:0][HW-1:0] h_q, h_new, pxe, lb_rd;
  logic [CH-1:0][HW-1:0] lb_q [MAX_COL/2];
  logic beat, last_col, last, cfg_ok, take;
`ifdef POOL_AVG_EN
  logic avg_q;
`else
  logic unused_avg;
  assign unused_avg = s.avg_mode;
`endif
  assign beat     = (state_q == RUN) && s.valid_in;
  assign last_col = c_q == col_q - 16'd1;
  assign last     = last_col && (r_q == row_q - 16'd1);
  assign take     = (state_q == IDLE) && s.start;
  assign cfg_ok   = s.pool_en ? (s.col >= 16'd2 && {1'b0, s.col} <= MAXC && s.row >= 16'd2)
                              : (s.col != 16'd0 && s.row != 16'd0);
  assign lb_rd    = lb_q[c_q[AW:1]];
  for (genvar k = 0; k < CH; k++) begin : g_ch
    logic signed [HW-1:0] px_e, hr, lr, hm, om;
    assign px_e   = HW'($signed(s.data_in[DW*k +: DW]));
    assign hr     = h_q[k];
    assign lr     = lb_rd[k];
    assign hm     = (hr > px_e) ? hr : px_e;
    assign om     = (lr > hm) ? lr : hm;
    assign pxe[k] = px_e;
`ifdef POOL_AVG_EN
    logic signed [HW-1:0] hs;
    logic signed [DW+1:0] tot;
    assign hs                 = hr + px_e;
    assign tot                = (DW+2)'(lr) + (DW+2)'(hs);
    assign h_new[k]           = avg_q ? hs : hm;
    assign pooled[DW*k +: DW] = avg_q ? DW'(tot >>> 2) : DW'(om);
`else
    assign h_new[k]           = hm;
    assign pooled[DW*k +: DW] = DW'(om);
`endif
  end
  // FSM state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  // FSM next state: accept a legal start, return to IDLE on the final beat
  always_comb begin
    state_d = state_q;
    if (take && cfg_ok) state_d = RUN;
    if (beat && last)   state_d = IDLE;
  end
  // FSM outputs
  always_comb begin
    s.busy      = state_q == RUN;
    s.cfg_err   = cfg_err_q;
    s.valid_out = valid_out_q;
    s.data_out  = data_out_q;
    s.pool_end  = pool_end_q;
  end
  // frame configuration, sticky config error and raster counters
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col_q     <= '0;
      row_q     <= '0;
      pool_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      c_q       <= '0;
      r_q       <= '0;
`ifdef POOL_AVG_EN
      avg_q     <= 1'b0;
`endif
    end else if (take) begin
      cfg_err_q <= !cfg_ok;
      if (cfg_ok) begin
        col_q  <= s.col;
        row_q  <= s.row;
        pool_q <= s.pool_en;
        c_q    <= '0;
        r_q    <= '0;
`ifdef POOL_AVG_EN
        avg_q  <= s.avg_mode;
`endif
      end
    end else if (beat) begin
      c_q <= last_col ? 16'd0 : c_q + 16'd1;
      r_q <= last_col ? r_q + 16'd1 : r_q;
    end
  // horizontal hold register and registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      h_q         <= '0;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
      pool_end_q  <= 1'b0;
    end else begin
      if (beat && !c_q[0]) h_q <= pxe;
      valid_out_q <= pool_q ? (beat && c_q[0] && r_q[0]) : beat;
      if (beat) data_out_q <= pool_q ? pooled : s.data_in;
      pool_end_q  <= beat && last;
    end
  // line buffer of horizontal results from even rows; never reset, always written before read
  always_ff @(posedge clk)
    if (beat && pool_q && c_q[0] && !r_q[0]) lb_q[c_q[AW:1]] <= h_new;
endmodule

// File: tb/tb_pool2d_stream.sv
// tb_pool2d_stream: directed frames with a scoreboard queue checked by an output monitor
module tb_pool2d_stream;
  localparam int CH = 4, DW = 8, MAX_COL = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0, errors = 0;
  logic [CH*DW-1:0] exp_q[$];
  pool2d_stream_if #(.CH(CH), .DW(DW)) m();
  pool2d_stream #(.CH(CH), .DW(DW), .MAX_COL(MAX_COL)) dut (.clk(clk), .rst_n(rst_n), .s(m));
  always #5 clk = ~clk;
  function automatic logic [31:0] px(int a, int b, int c, int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction
  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic do_start(int c, int r, bit pe, bit av, bit ok);
    @(negedge clk);
    m.valid_in = 1'b0; m.start = 1'b1; m.col = 16'(c); m.row = 16'(r);
    m.pool_en = pe; m.avg_mode = av;
    @(negedge clk);
    m.start = 1'b0;
    chk("busy_after_start", m.busy, ok);
    chk("cfg_err_after_start", m.cfg_err, !ok);
  endtask
  task automatic beat(logic [31:0] d);
    @(negedge clk);
    m.valid_in = 1'b1; m.data_in = d;
  endtask
  task automatic idle();
    @(negedge clk);
    m.valid_in = 1'b0;
  endtask
  task automatic end_frame(bit vo);
    idle();
    chk("pool_end_after_last", m.pool_end, 1);
    chk("busy_after_last", m.busy, 0);
    chk("valid_out_with_pool_end", m.valid_out, vo);
    idle();
    chk("pool_end_pulse", m.pool_end, 0);
  endtask
  always @(negedge clk)
    if (rst_n && m.valid_out) begin
      logic [CH*DW-1:0] e;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: got %0h expected none", m.data_out);
      end else begin
        e = exp_q.pop_front();
        chk("data_out", m.data_out, e);
      end
    end
  initial begin
    int gap[6];
    logic [31:0] bd;
    gap = '{1, 0, 2, 1, 3, 0};
    m.start = 0; m.col = 0; m.row = 0; m.pool_en = 0; m.avg_mode = 0;
    m.valid_in = 0; m.data_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid_out", m.valid_out, 0);
    chk("rst_data_out", m.data_out, 0);
    chk("rst_pool_end", m.pool_end, 0);
    chk("rst_busy", m.busy, 0);
    chk("rst_cfg_err", m.cfg_err, 0);
    rst_n = 1'b1;
    // 4x4 ramp: ch0 = r*4+c, ch1 = -(r*4+c)
    do_start(4, 4, 1, 0, 1);
    exp_q.push_back(px(5, 0, 0, 0));
    exp_q.push_back(px(7, -2, 0, 0));
    exp_q.push_back(px(13, -8, 0, 0));
    exp_q.push_back(px(15, -10, 0, 0));
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) beat(px(r*4+c, -(r*4+c), 0, 0));
    end_frame(1);
    // illegal configurations
    do_start(1, 4, 1, 0, 0);
    do_start(MAX_COL + 2, 2, 1, 0, 0);
    // negative data and ties, 2x2 (clears cfg_err)
    do_start(2, 2, 1, 0, 1);
    exp_q.push_back(px(-1, 127, -3, 0));
    beat(px(-128, 127, -3, 0));
    beat(px(-1, 0, -3, 0));
    beat(px(-5, 0, -3, 0));
    beat(px(-100, 0, -3, 0));
    end_frame(1);
    // 5x3: column 4 and row 2 discarded
    do_start(5, 3, 1, 0, 1);
    exp_q.push_back(px(6, 100, 0, 0));
    exp_q.push_back(px(8, 98, 0, 0));
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 5; c++) beat(px(r*5+c, 100-(r*5+c), 0, 0));
    end_frame(0);
    // bypass 3x2 with gaps
    do_start(3, 2, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      bd = px(i, i*3, 'hA0+i, 'h5A^i);
      exp_q.push_back(bd);
      beat(bd);
      repeat (gap[i]) idle();
    end
    end_frame(1);
    // reset mid-row 1, then a fresh frame
    do_start(4, 4, 1, 0, 1);
    for (int i = 0; i < 5; i++) beat(px(99, 99, 99, 99));
    @(negedge clk);
    m.valid_in = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", m.busy, 0);
    chk("async_rst_valid_out", m.valid_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    beat(px(1, 2, 3, 4));
    idle();
    idle();
    do_start(4, 4, 1, 0, 1);
    exp_q.push_back(px(15, 0, 0, 0));
    exp_q.push_back(px(13, 0, 0, 0));
    exp_q.push_back(px(7, 0, 0, 0));
    exp_q.push_back(px(5, 0, 0, 0));
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) beat(px(15-(r*4+c), 0, 0, 0));
    end_frame(1);
`ifdef POOL_AVG_EN
    do_start(2, 2, 1, 1, 1);
    exp_q.push_back(px(-1, 0, 0, 0));
    beat(px(1, 0, 0, 0));
    beat(px(2, 0, 0, 0));
    beat(px(3, 0, 0, 0));
    beat(px(-7, 0, 0, 0));
    end_frame(1);
`endif
    repeat (3) idle();
    chk("queue_drained", 64'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
